// File: rtl/rv_multicycle_ctrl_if.sv
// rv_multicycle_ctrl_if: control-unit bus between the sequencer (master) and the datapath/memories (slave).
interface rv_multicycle_ctrl_if #(
   parameter int COUNT_W = 16
);
   logic               run;
   logic [31:0]        instr;
   logic               alu_zero;
   logic [4:0]         rs1;
   logic [4:0]         rs2;
   logic [4:0]         rd;
   logic [31:0]        imm;
   logic [2:0]         alu_control;
   logic               alu_src_b;
   logic               reg_bank_write;
   logic [1:0]         wb_sel;
   logic               dmem_wren;
   logic               pc_en;
   logic [1:0]         pc_sel;
   logic               busy;
   logic               illegal;
   logic [COUNT_W-1:0] instr_count;

   modport master (
      input  run, instr, alu_zero,
      output rs1, rs2, rd, imm, alu_control, alu_src_b, reg_bank_write, wb_sel,
             dmem_wren, pc_en, pc_sel, busy, illegal, instr_count
   );

   modport slave (
      output run, instr, alu_zero,
      input  rs1, rs2, rd, imm, alu_control, alu_src_b, reg_bank_write, wb_sel,
             dmem_wren, pc_en, pc_sel, busy, illegal, instr_count
   );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: Moore multi-cycle sequencer for the RV32I subset (R, I-ALU, LW, SW, BEQ/BNE, JAL).
module rv_multicycle_ctrl #(
   parameter int COUNT_W = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   rv_multicycle_ctrl_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITE_BACK, S_PC_UPDATE, S_TRAP
   } state_e;

   typedef enum logic [2:0] {C_ILL, C_R, C_I, C_LW, C_SW, C_BR, C_JAL} cls_e;

   function automatic cls_e classify(input logic [31:0] ir);
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = ir[14:12];
      f7 = ir[31:25];
      case (ir[6:0])
         7'b0110011: return ((f7 == 7'h00 && f3 != 3'b011) || (f7 == 7'h20 && f3 == 3'b000)) ? C_R : C_ILL;
         7'b0010011: return (f3 != 3'b011 && (f3[1:0] != 2'b01 || f7 == 7'h00)) ? C_I : C_ILL;
         7'b0000011: return (f3 == 3'b010) ? C_LW : C_ILL;
         7'b0100011: return (f3 == 3'b010) ? C_SW : C_ILL;
         7'b1100011: return (f3[2:1] == 2'b00) ? C_BR : C_ILL;
         7'b1101111: return C_JAL;
         default:    return C_ILL;
      endcase
   endfunction

   // funct3 maps identically for R and I forms; only R with funct7[5] selects SUB
   function automatic logic [2:0] alu_op(input logic [31:0] ir);
      case (ir[14:12])
         3'b000:  return (ir[5] && ir[30]) ? 3'b001 : 3'b000;
         3'b111:  return 3'b010;
         3'b110:  return 3'b011;
         3'b100:  return 3'b100;
         3'b001:  return 3'b101;
         3'b101:  return 3'b110;
         default: return 3'b111;
      endcase
   endfunction

   state_e             state_q, state_d;
   logic [31:0]        ir_q;
   logic               br_q;
   logic [COUNT_W-1:0] cnt_q;
   cls_e               cls, cls_in;
   logic               alu_active;

   assign cls    = classify(ir_q);
   assign cls_in = classify(bus.instr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ir_q    <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) ir_q <= bus.instr;
         // ir_q[12] distinguishes BNE from BEQ
         if (state_q == S_EXECUTE) br_q <= (cls == C_BR) && (ir_q[12] ^ bus.alu_zero);
         if (state_q == S_PC_UPDATE) cnt_q <= cnt_q + COUNT_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:       state_d = bus.run ? S_FETCH : S_IDLE;
         S_FETCH:      state_d = S_DECODE;
         S_DECODE:     state_d = (cls_in == C_ILL) ? S_TRAP : (cls_in == C_JAL) ? S_WRITE_BACK : S_EXECUTE;
         S_EXECUTE:    state_d = (cls == C_BR) ? S_PC_UPDATE : (cls == C_LW || cls == C_SW) ? S_MEM : S_WRITE_BACK;
         S_MEM:        state_d = (cls == C_LW) ? S_WRITE_BACK : S_PC_UPDATE;
         S_WRITE_BACK: state_d = S_PC_UPDATE;
         S_PC_UPDATE:  state_d = bus.run ? S_FETCH : S_IDLE;
         default:      state_d = S_TRAP;
      endcase
   end

   assign alu_active = state_q == S_EXECUTE || state_q == S_MEM || state_q == S_WRITE_BACK;

   always_comb begin
      bus.imm = '0;
      case (cls)
         C_I, C_LW: bus.imm = {{20{ir_q[31]}}, ir_q[31:20]};
         C_SW:      bus.imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
         C_BR:      bus.imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
         C_JAL:     bus.imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
         default:   bus.imm = '0;
      endcase
      bus.alu_control = !alu_active ? 3'b000 :
                        (cls == C_BR) ? 3'b001 :
                        (cls == C_R || cls == C_I) ? alu_op(ir_q) : 3'b000;
      bus.alu_src_b = alu_active && (cls == C_I || cls == C_LW || cls == C_SW);
      bus.reg_bank_write = state_q == S_WRITE_BACK && ir_q[11:7] != 5'd0;
      bus.wb_sel = (state_q != S_WRITE_BACK) ? 2'b00 : (cls == C_LW) ? 2'b01 : (cls == C_JAL) ? 2'b10 : 2'b00;
      bus.dmem_wren = state_q == S_MEM && cls == C_SW;
      bus.pc_en = state_q == S_PC_UPDATE;
      bus.pc_sel = (state_q == S_PC_UPDATE && (cls == C_JAL || (cls == C_BR && br_q))) ? 2'b01 : 2'b00;
      bus.busy = state_q != S_IDLE && state_q != S_TRAP;
      bus.illegal = state_q == S_TRAP;
   end

   assign bus.rs1         = ir_q[19:15];
   assign bus.rs2         = ir_q[24:20];
   assign bus.rd          = ir_q[11:7];
   assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb_rv_multicycle_ctrl: directed per-cycle checks of the multi-cycle control unit.
module tb_rv_multicycle_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          checks = 0;
   int          errors = 0;
   int          exp_cnt = 0;
   logic [12:0] ctl, bz, pu0, pu1, ill;

   rv_multicycle_ctrl_if #(.COUNT_W(16)) bus ();
   rv_multicycle_ctrl #(.COUNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   assign ctl = {bus.reg_bank_write, bus.wb_sel, bus.dmem_wren, bus.pc_en, bus.pc_sel,
                 bus.alu_control, bus.alu_src_b, bus.busy, bus.illegal};

   function automatic logic [12:0] mk(input int rbw, wb, dw, pe, ps, alu, sb, bsy, il);
      return {1'(rbw), 2'(wb), 1'(dw), 1'(pe), 2'(ps), 3'(alu), 1'(sb), 1'(bsy), 1'(il)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic [12:0] e);
      @(posedge clk);
      #1;
      chk(tag, 32'(ctl), 32'(e));
   endtask

   initial begin
      bz  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
      pu0 = mk(0, 0, 0, 1, 0, 0, 0, 1, 0);
      pu1 = mk(0, 0, 0, 1, 1, 0, 0, 1, 0);
      ill = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
      bus.run = 1'b0;
      bus.instr = '0;
      bus.alu_zero = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ctl", 32'(ctl), 0);
      chk("rst_regs", 32'({bus.rs1, bus.rs2, bus.rd}), 0);
      chk("rst_imm", bus.imm, 0);
      chk("rst_cnt", 32'(bus.instr_count), 0);
      rst_n = 1'b1;
      bus.run = 1'b1;
      bus.instr = 32'h002081B3;
      step("add_fetch", bz);
      step("add_decode", bz);
      step("add_exec", mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
      chk("add_regs", 32'({bus.rs1, bus.rs2, bus.rd}), 32'({5'd1, 5'd2, 5'd3}));
      step("add_wb", mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
      step("add_pcu", pu0);
      exp_cnt++;
      bus.instr = 32'h407302B3;
      step("sub_fetch", bz);
      chk("cnt_add", 32'(bus.instr_count), exp_cnt);
      step("sub_decode", bz);
      step("sub_exec", mk(0, 0, 0, 0, 0, 1, 0, 1, 0));
      chk("sub_regs", 32'({bus.rs1, bus.rs2, bus.rd}), 32'({5'd6, 5'd7, 5'd5}));
      step("sub_wb", mk(1, 0, 0, 0, 0, 1, 0, 1, 0));
      step("sub_pcu", pu0);
      exp_cnt++;
      bus.instr = 32'hFFF00093;
      step("addi_fetch", bz);
      step("addi_decode", bz);
      step("addi_exec", mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
      chk("addi_imm", bus.imm, 32'hFFFFFFFF);
      step("addi_wb", mk(1, 0, 0, 0, 0, 0, 1, 1, 0));
      chk("addi_rd", 32'(bus.rd), 1);
      step("addi_pcu", pu0);
      exp_cnt++;
      bus.instr = 32'h00812203;
      step("lw_fetch", bz);
      step("lw_decode", bz);
      step("lw_exec", mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
      chk("lw_imm", bus.imm, 8);
      step("lw_mem", mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
      step("lw_wb", mk(1, 1, 0, 0, 0, 0, 1, 1, 0));
      chk("lw_rd", 32'(bus.rd), 4);
      step("lw_pcu", pu0);
      exp_cnt++;
      bus.instr = 32'h00412623;
      step("sw_fetch", bz);
      chk("cnt_lw", 32'(bus.instr_count), exp_cnt);
      step("sw_decode", bz);
      step("sw_exec", mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
      chk("sw_imm", bus.imm, 12);
      step("sw_mem", mk(0, 0, 1, 0, 0, 0, 1, 1, 0));
      step("sw_pcu", pu0);
      exp_cnt++;
      bus.instr = 32'h00208863;
      bus.alu_zero = 1'b1;
      step("beq1_fetch", bz);
      step("beq1_decode", bz);
      step("beq1_exec", mk(0, 0, 0, 0, 0, 1, 0, 1, 0));
      chk("beq_imm", bus.imm, 16);
      step("beq1_pcu", pu1);
      exp_cnt++;
      bus.alu_zero = 1'b0;
      step("beq0_fetch", bz);
      step("beq0_decode", bz);
      step("beq0_exec", mk(0, 0, 0, 0, 0, 1, 0, 1, 0));
      step("beq0_pcu", pu0);
      exp_cnt++;
      bus.instr = 32'h00209863;
      step("bne0_fetch", bz);
      step("bne0_decode", bz);
      step("bne0_exec", mk(0, 0, 0, 0, 0, 1, 0, 1, 0));
      step("bne0_pcu", pu1);
      exp_cnt++;
      bus.alu_zero = 1'b1;
      step("bne1_fetch", bz);
      step("bne1_decode", bz);
      step("bne1_exec", mk(0, 0, 0, 0, 0, 1, 0, 1, 0));
      step("bne1_pcu", pu0);
      exp_cnt++;
      bus.alu_zero = 1'b0;
      bus.instr = 32'h001000EF;
      step("jal_fetch", bz);
      step("jal_decode", bz);
      step("jal_wb", mk(1, 2, 0, 0, 0, 0, 0, 1, 0));
      chk("jal_imm", bus.imm, 32'h00000800);
      step("jal_pcu", pu1);
      exp_cnt++;
      bus.instr = 32'h00208033;
      step("x0_fetch", bz);
      chk("cnt_jal", 32'(bus.instr_count), exp_cnt);
      step("x0_decode", bz);
      step("x0_exec", bz);
      step("x0_wb", bz);
      step("x0_pcu", pu0);
      exp_cnt++;
      bus.instr = 32'h002081B3;
      step("stop_fetch", bz);
      step("stop_decode", bz);
      step("stop_exec", bz);
      bus.run = 1'b0;
      step("stop_wb", mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
      step("stop_pcu", pu0);
      exp_cnt++;
      step("stop_idle", 13'd0);
      step("stop_idle2", 13'd0);
      chk("cnt_stop", 32'(bus.instr_count), exp_cnt);
      bus.run = 1'b1;
      step("rwb_fetch", bz);
      step("rwb_decode", bz);
      step("rwb_exec", bz);
      step("rwb_wb", mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
      #2;
      rst_n = 1'b0;
      #1;
      chk("rwb_ctl", 32'(ctl), 0);
      chk("rwb_regs", 32'({bus.rs1, bus.rs2, bus.rd}), 0);
      chk("rwb_cnt", 32'(bus.instr_count), 0);
      @(posedge clk);
      #1;
      chk("rwb_idle", 32'(ctl), 0);
      rst_n = 1'b1;
      bus.instr = 32'hFFFFFFFF;
      step("trap_fetch", bz);
      step("trap_decode", bz);
      step("trap_enter", ill);
      for (int i = 0; i < 100; i++) step("trap_hold", ill);
      rst_n = 1'b0;
      #1;
      chk("trap_rst", 32'(ctl), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.instr = 32'h0020B1B3;
      step("sltu_fetch", bz);
      step("sltu_decode", bz);
      step("sltu_trap", ill);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
- Multi-cycle control unit for the RV32I-subset CPU.
- Sequences instruction fetch, decode, ALU execute, data-memory access, register write-back and PC update.
- Drives the control inputs of the datapath, PC register, instruction memory and data memory.
- Replaces the ad-hoc R-type-only sequencer. Decodes R, I-ALU, LW, SW, BEQ/BNE and JAL, and traps on anything else.

Parameters:
COUNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
run  in  1  1 = allowed to leave IDLE and fetch
instr  in  32  instruction memory q; valid the cycle after FETCH
alu_zero  in  1  datapath ALU result == 0
rs1  out  5  IR[19:15]
rs2  out  5  IR[24:20]
rd  out  5  IR[11:7]
imm  out  32  sign-extended immediate for current IR format
alu_control  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SLT
alu_src_b  out  1  0 = rs2 data, 1 = imm
reg_bank_write  out  1  register bank write enable
wb_sel  out  2  00 ALU, 01 dmem q, 10 PC+4
dmem_wren  out  1  data memory write enable
pc_en  out  1  PC load enable
pc_sel  out  2  00 PC+4, 01 PC+imm
busy  out  1  state != IDLE and != TRAP
illegal  out  1  sticky illegal-instruction flag
instr_count  out  COUNT_W  retired instructions, wraps

Behaviour:
- Reset (asynchronous, immediate, including mid-instruction):
  - state = IDLE; IR = 0; branch flag = 0; instr_count = 0.
  - Every output is 0.
- Output style: Moore. All enables are single-cycle pulses, decoded from the state and IR.
- State transitions:
  - IDLE: if run, go to FETCH.
  - FETCH: PC drives imem address. Go to DECODE.
  - DECODE: IR <= instr. Classify the opcode:
    - unsupported opcode/funct → TRAP
    - JAL → WRITE_BACK
    - otherwise → EXECUTE
  - EXECUTE → next state by class:
    - BRANCH: alu_control = SUB, alu_src_b = 0; taken flag <= (BEQ & alu_zero) | (BNE & !alu_zero); → PC_UPDATE.
    - LW/SW: ADD, alu_src_b = 1 → MEM.
    - R-type: alu_src_b = 0 → WRITE_BACK.
    - I-ALU: alu_src_b = 1 → WRITE_BACK.
  - MEM: SW asserts dmem_wren and goes to PC_UPDATE. LW does not assert dmem_wren (q is valid next cycle) and goes to WRITE_BACK.
  - WRITE_BACK:
    - reg_bank_write = (rd != 0).
    - wb_sel: 01 for LW, 10 for JAL, else 00.
    - alu_control and alu_src_b stay held from EXECUTE.
    - Go to PC_UPDATE.
  - PC_UPDATE:
    - pc_en = 1.
    - pc_sel = 01 for JAL or taken branch, else 00.
    - instr_count += 1 (wraps at 2^COUNT_W).
    - Go to FETCH if run, else IDLE.
  - TRAP: illegal = 1. No writes, no pc_en. Exit only via reset.
- Cycles per instruction (FETCH to PC_UPDATE inclusive):
  - R/I-ALU: 5
  - LW: 6
  - SW: 5
  - BRANCH: 4
  - JAL: 4
- Decode. Opcode 0110011 is R-type:
  - funct7 0000000 with funct3 000/111/110/100/001/101/010 → ADD/AND/OR/XOR/SLL/SRL/SLT.
  - funct7 0100000 with funct3 000 → SUB.
  - Anything else → TRAP.
- Decode. Opcode 0010011 is I-type:
  - funct3 000/111/110/100/010 → ADDI/ANDI/ORI/XORI/SLTI.
  - funct3 001 or 101 with IR[31:25] = 0 → SLLI/SRLI.
  - Anything else → TRAP.
- Decode, other opcodes:
  - LW is 0000011 and SW is 0100011; both require funct3 010, else TRAP.
  - BRANCH is 1100011 with funct3 000 (BEQ) or 001 (BNE), else TRAP.
  - JAL is 1101111.
- Immediates:
  - I: sext(IR[31:20]).
  - S: sext({IR[31:25], IR[11:7]}).
  - B: sext({IR[31], IR[7], IR[30:25], IR[11:8], 0}).
  - J: sext({IR[31], IR[19:12], IR[20], IR[30:21], 0}).
  - R: 0.
- run deasserted mid-instruction: the current instruction completes; the FSM then returns to IDLE after PC_UPDATE.
- rd = x0: the full sequence executes, but reg_bank_write stays 0.

Test Plan:
- Reset then run=1, instr=ADD x3,x1,x2 (0x002081B3):
  - States IDLE, FETCH, DECODE, EXECUTE, WRITE_BACK, PC_UPDATE.
  - alu_control = 000; reg_bank_write one cycle with rd = 3; pc_en one cycle with pc_sel = 00; instr_count = 1.
- SUB x5,x6,x7 (0x407302B3) → alu_control = 001. ADDI x1,x0,-1 (0xFFF00093) → imm = 0xFFFFFFFF, alu_src_b = 1.
- LW x4,8(x2) (0x00812203):
  - 6 cycles; no dmem_wren.
  - WRITE_BACK has wb_sel = 01, rd = 4.
  - SW x4,12(x2) (0x00412623): dmem_wren in MEM, imm = 12, no reg write.
- BEQ x1,x2,+16 (0x00208863):
  - alu_zero = 1 in EXECUTE → pc_sel = 01, imm = 16.
  - Repeat with alu_zero = 0 → pc_sel = 00.
  - BNE: inverse of BEQ.
- JAL x1,+2048 (0x001000EF) → 4 cycles; wb_sel = 10; imm = 0x00000800; pc_sel = 01.
- Error and control cases:
  - instr = 0xFFFFFFFF → TRAP; illegal = 1 held for 100 cycles; no enables asserted.
  - rst_n low asserted mid-WRITE_BACK → all outputs 0 immediately; state IDLE.
  - run dropped in EXECUTE → instruction retires, then IDLE.
